// File: rtl/uart_tx_fsm.sv
// Frame sequencer for the UART TX datapath: START -> DATA -> [PARITY] -> STOP.
// Optional second stop bit via UART_TX_TWO_STOP_EN.
module uart_tx_fsm #(
    parameter int WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Data_Valid,
    input  logic       PAR_EN,
    input  logic       PAR_TYP,
    output logic       ser_load,
    output logic       ser_en,
    output logic [1:0] mux_sel,
    output logic       busy,
    output logic       par_en_o,
    output logic       par_typ_o
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

`ifdef UART_TX_TWO_STOP_EN
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4,
        STOP2  = 3'd5
    } state_t;
`else
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;
`endif

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] bit_cnt_reg, bit_cnt_next;
    logic             par_en_reg, par_typ_reg;
    logic             accept;

    assign accept = (state_reg == IDLE) && Data_Valid;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_reg   <= IDLE;
            bit_cnt_reg <= '0;
            par_en_reg  <= 1'b0;
            par_typ_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            bit_cnt_reg <= bit_cnt_next;
            // Parity configuration is frozen for the frame at the accepting edge
            if (accept) begin
                par_en_reg  <= PAR_EN;
                par_typ_reg <= PAR_TYP;
            end
        end
    end

    always_comb begin
        state_next   = state_reg;
        bit_cnt_next = bit_cnt_reg;
        case (state_reg)
            IDLE: begin
                bit_cnt_next = '0;
                if (Data_Valid) begin
                    state_next = START;
                end
            end
            START: begin
                bit_cnt_next = '0;
                state_next   = DATA;
            end
            DATA: begin
                if (bit_cnt_reg == LAST_BIT) begin
                    bit_cnt_next = '0;
                    state_next   = par_en_reg ? PARITY : STOP;
                end else begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                end
            end
            PARITY: begin
                state_next = STOP;
            end
            STOP: begin
`ifdef UART_TX_TWO_STOP_EN
                state_next = STOP2;
`else
                state_next = IDLE;
`endif
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                state_next = IDLE;
            end
`endif
            default: begin
                bit_cnt_next = '0;
                state_next   = IDLE;
            end
        endcase
    end

    // Outputs decode the state register only, so inputs never reach them combinationally
    always_comb begin
        ser_load = 1'b0;
        ser_en   = 1'b0;
        mux_sel  = 2'b01;
        busy     = 1'b1;
        case (state_reg)
            IDLE: begin
                busy = 1'b0;
            end
            START: begin
                mux_sel  = 2'b00;
                ser_load = 1'b1;
            end
            DATA: begin
                mux_sel = 2'b10;
                ser_en  = 1'b1;
            end
            PARITY: begin
                mux_sel = 2'b11;
            end
            STOP: begin
                mux_sel = 2'b01;
            end
`ifdef UART_TX_TWO_STOP_EN
            STOP2: begin
                mux_sel = 2'b01;
            end
`endif
            default: begin
                busy = 1'b0;
            end
        endcase
    end

    assign par_en_o  = par_en_reg;
    assign par_typ_o = par_typ_reg;

endmodule

// File: tb/tb_uart_tx_fsm.sv
// Self-checking bench for uart_tx_fsm: directed and random frames against a
// queue-based frame model, plus a small bench-side serializer to form the line.
module tb_uart_tx_fsm;

    localparam int W = 8;

    logic       CLK = 1'b0;
    logic       RST = 1'b0;
    logic       Data_Valid = 1'b0;
    logic       PAR_EN = 1'b0;
    logic       PAR_TYP = 1'b0;
    logic       ser_load, ser_en, busy, par_en_o, par_typ_o;
    logic [1:0] mux_sel;

    int checks = 0;
    int errors = 0;

    logic [W-1:0] tx_data = '0;
    logic [W-1:0] sh;
    logic         line;

    uart_tx_fsm #(.WIDTH(W)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .Data_Valid(Data_Valid),
        .PAR_EN    (PAR_EN),
        .PAR_TYP   (PAR_TYP),
        .ser_load  (ser_load),
        .ser_en    (ser_en),
        .mux_sel   (mux_sel),
        .busy      (busy),
        .par_en_o  (par_en_o),
        .par_typ_o (par_typ_o)
    );

    always #5 CLK = ~CLK;

    // Bench-side serializer and output mux driven by the DUT controls
    always @(posedge CLK or negedge RST) begin
        if (!RST)          sh <= '0;
        else if (ser_load) sh <= tx_data;
        else if (ser_en)   sh <= sh >> 1;
    end

    always_comb begin
        line = 1'b1;
        case (mux_sel)
            2'b00: line = 1'b0;
            2'b01: line = 1'b1;
            2'b10: line = sh[0];
            2'b11: line = (^tx_data) ^ par_typ_o;
            default: line = 1'bx;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    // Send one frame and check every busy cycle against the reference frame.
    task automatic frame(input logic [W-1:0] d, input logic pe, input logic pt,
                         input bit noisy, input int dv_a, input int dv_b, input int tog_at);
        logic [1:0] mq[$];
        logic       lq[$];
        mq.push_back(2'b00); lq.push_back(1'b0);
        for (int b = 0; b < W; b++) begin
            mq.push_back(2'b10); lq.push_back(d[b]);
        end
        if (pe) begin
            mq.push_back(2'b11); lq.push_back((^d) ^ pt);
        end
        mq.push_back(2'b01); lq.push_back(1'b1);
`ifdef UART_TX_TWO_STOP_EN
        mq.push_back(2'b01); lq.push_back(1'b1);
`endif
        tx_data    = d;
        PAR_EN     = pe;
        PAR_TYP    = pt;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < mq.size(); i++) begin
            chk($sformatf("busy[%0d]", i), 32'(busy), 32'd1);
            chk($sformatf("mux_sel[%0d]", i), 32'(mux_sel), 32'(mq[i]));
            chk($sformatf("ser_en[%0d]", i), 32'(ser_en), 32'(mq[i] == 2'b10));
            chk($sformatf("ser_load[%0d]", i), 32'(ser_load), 32'(i == 0));
            chk($sformatf("par_en_o[%0d]", i), 32'(par_en_o), 32'(pe));
            chk($sformatf("par_typ_o[%0d]", i), 32'(par_typ_o), 32'(pt));
            chk($sformatf("line[%0d]", i), 32'(line), 32'(lq[i]));
            Data_Valid = (i == dv_a) || (i == dv_b);
            if (noisy) begin
                PAR_EN  = 1'($urandom);
                PAR_TYP = 1'($urandom);
            end
            if (i == tog_at) PAR_EN = ~pe;
            tick();
        end
        Data_Valid = 1'b0;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_mux", 32'(mux_sel), 32'd1);
        chk("idle_load", 32'(ser_load), 32'd0);
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mux", 32'(mux_sel), 32'd1);
        chk("rst_ser_en", 32'(ser_en), 32'd0);
        chk("rst_ser_load", 32'(ser_load), 32'd0);
        chk("rst_par_en_o", 32'(par_en_o), 32'd0);
        chk("rst_par_typ_o", 32'(par_typ_o), 32'd0);
        #10;
        RST = 1'b1;
        tick();
        chk("post_rst_busy", 32'(busy), 32'd0);

        // Directed frames, issued back-to-back (single idle cycle between them)
        frame(8'hA5, 1'b1, 1'b0, 1'b0, -1, -1, -1);
        frame(8'hA5, 1'b1, 1'b1, 1'b0, -1, -1, -1);
        frame(8'hA5, 1'b0, 1'b0, 1'b0, -1, -1, -1);
        frame(8'h3C, 1'b1, 1'b0, 1'b0, 2, 8, -1);
        tick();
        chk("no_second_frame", 32'(busy), 32'd0);
        frame(8'h5A, 1'b1, 1'b0, 1'b0, -1, -1, 4);
        frame(8'h5A, 1'b0, 1'b1, 1'b0, -1, -1, -1);

        // Random frames with noisy parity inputs and random idle gaps
        for (int n = 0; n < 20; n++) begin
            frame(W'($urandom), 1'($urandom), 1'($urandom), 1'b1, -1, -1, -1);
            for (int g = 0; g < int'($urandom_range(2, 0)); g++) begin
                tick();
                chk("gap_busy", 32'(busy), 32'd0);
            end
        end

        // Asynchronous reset in the middle of DATA
        tx_data    = 8'hFF;
        PAR_EN     = 1'b1;
        PAR_TYP    = 1'b1;
        Data_Valid = 1'b1;
        tick();
        Data_Valid = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("pre_rst_ser_en", 32'(ser_en), 32'd1);
        #2;
        RST = 1'b0;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_mux", 32'(mux_sel), 32'd1);
        chk("mid_rst_ser_en", 32'(ser_en), 32'd0);
        chk("mid_rst_par_en_o", 32'(par_en_o), 32'd0);
        tick();
        RST = 1'b1;
        tick();
        tick();
        chk("after_rst_busy", 32'(busy), 32'd0);
        chk("after_rst_mux", 32'(mux_sel), 32'd1);
        chk("after_rst_load", 32'(ser_load), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
